iterative_shift_unit: RTL
=========================

// Module: iterative_shift_unit
// PURPOSE
//   Multi-cycle 32-bit shifter for the ALU side-path: one shift op per handshake, executed as shamt
//   successive 1-bit steps through the single-bit shift stages (my_1bit_rightshifter and a matching
//   left stage), so only one 1-bit datapath is instantiated per direction. Sits between decode/issue
//   (upstream, valid/ready) and writeback select (downstream, valid/ready); drives the stages'
//   control_bit and data_input each step and registers their output.
// PARAMETERS
//   WIDTH    32  operand/result width
//   SHAMT_W  5   shift-amount width; equals clog2(WIDTH)
// PORTS
//   clock     in   1        single clock; all state updates on rising edge
//   reset     in   1        synchronous, active-high; sampled on rising edge of clock
//   flush     in   1        synchronous pipeline flush; aborts any op in flight
//   in_valid  in   1        upstream op present
//   in_ready  out  1        unit can accept op (high only in IDLE)
//   data_in   in   WIDTH    operand
//   shamt     in   SHAMT_W  shift amount, 0..WIDTH-1
//   op        in   2        00 SLL, 01 SRL, 11 SRA, 10 reserved (behaves as 00)
//   out_valid out  1        result available
//   out_ready in   1        downstream accepts result
//   data_out  out  WIDTH    result register
//   busy      out  1        high in BUSY or DONE
// BEHAVIOUR
//   States: IDLE, BUSY, DONE. Reset -> IDLE, data_out=0, out_valid=0, busy=0, in_ready=1, count=0.
//   Priority per edge: reset > flush > normal operation.
//   IDLE: in_ready=1. Accept when in_valid & in_ready: latch data_in into work reg, op into op reg,
//     count<=shamt. shamt==0 -> DONE, else -> BUSY.
//   BUSY: each cycle work reg <= 1-bit shift of itself; count<=count-1; when count==1 this cycle -> DONE.
//     SLL: {w[WIDTH-2:0],1'b0}. SRL: {1'b0,w[WIDTH-1:1]}. SRA: {w[WIDTH-1],w[WIDTH-1:1]} (sign fill).
//   DONE: out_valid=1, data_out=work reg, held stable until out_valid & out_ready, then -> IDLE.
//     No accept in DONE (in_ready=0); next op accepted earliest the cycle after handshake.
//   Latency: first out_valid cycle is shamt+1 cycles after accept cycle (shamt=0 -> next cycle).
//   Throughput: one op per shamt+2 cycles with out_ready held high.
//   flush: any state -> IDLE next cycle; out_valid=0, result discarded; flush with in_valid in IDLE
//     -> op NOT accepted. data_out not cleared by flush (don't-care while out_valid=0).
//   reset mid-op: same as flush plus data_out=0.
//   Inputs data_in/shamt/op ignored outside the accept cycle; changes while busy have no effect.
//   in_ready, out_valid, busy decoded from state register only (no comb path from in_valid/out_ready).
// STRUCTURE
//   Shared include alu_shift_defs.vh: op encodings (SHIFT_SLL/SRL/SRA), state encodings, WIDTH default.
//   Sub-modules: my_1bit_rightshifter (SRA step; SRL via top bit forced 0 before it) and new
//   my_1bit_leftshifter (SLL step, zero fill). Top level holds FSM, counter, work reg, op mux.
// TESTING
//   1 SRA 0x8000_0010, shamt 4 -> out_valid 5 cycles after accept, data_out 0xF800_0001.
//   2 SLL 0x0000_0001, shamt 31 -> data_out 0x8000_0000 after 32 cycles; in_ready 0 until handshake.
//   3 SRL 0xDEAD_BEEF, shamt 0 -> out_valid next cycle, data_out 0xDEAD_BEEF; SRL 0x8000_0000 shamt 1 -> 0x4000_0000.
//   4 out_ready low 10 cycles in DONE -> out_valid/data_out stable, in_valid pulses ignored, no accept.
//   5 flush at 3rd BUSY cycle of shamt 20 -> IDLE next cycle, out_valid never rises; next op SLL
//     0x0000_00FF shamt 8 -> 0x0000_FF00 correct.
//   6 reset asserted in DONE -> next cycle out_valid=0, data_out=0, in_ready=1; op=10 shamt 2 on
//     0x3 -> 0xC (behaves as SLL).

Source files
------------

// File: rtl/iterative_shift_unit_pkg.sv
// ============================================================================
// Module  : iterative_shift_unit_pkg
// Brief   : Shared op encodings, FSM state type and width defaults for the
//           iterative shift unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iterative_shift_unit_pkg;

    localparam int c_WIDTH_DEFAULT = 32;

    localparam logic [1:0] c_SHIFT_SLL = 2'b00;
    localparam logic [1:0] c_SHIFT_SRL = 2'b01;
    localparam logic [1:0] c_SHIFT_RSV = 2'b10;
    localparam logic [1:0] c_SHIFT_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The reserved encoding falls through to SLL, so only SRL/SRA go right.
    function automatic logic op_is_right(input logic [1:0] op);
        return (op == c_SHIFT_SRL) || (op == c_SHIFT_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iterative_shift_unit_stages.sv
// ============================================================================
// Module  : my_1bit_rightshifter / my_1bit_leftshifter
// Brief   : Single-bit shift stages; control_bit is the bit shifted in.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module my_1bit_rightshifter #(
    parameter int WIDTH = 32
) (
    input  logic             control_bit,
    input  logic [WIDTH-1:0] data_input,
    output logic [WIDTH-1:0] data_output
);

    assign data_output = (data_input >> 1) | {control_bit, {(WIDTH-1){1'b0}}};

endmodule

module my_1bit_leftshifter #(
    parameter int WIDTH = 32
) (
    input  logic             control_bit,
    input  logic [WIDTH-1:0] data_input,
    output logic [WIDTH-1:0] data_output
);

    assign data_output = (data_input << 1) | {{(WIDTH-1){1'b0}}, control_bit};

endmodule

`default_nettype wire

// File: rtl/iterative_shift_unit.sv
// ============================================================================
// Module  : iterative_shift_unit
// Brief   : Multi-cycle shifter executing shamt single-bit steps per op,
//           with valid/ready handshakes on both sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_shift_unit
    import iterative_shift_unit_pkg::*;
#(
    parameter int WIDTH   = c_WIDTH_DEFAULT,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_data_out;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_op;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_right_fill;
    logic [WIDTH-1:0]   w_right;
    logic [WIDTH-1:0]   w_left;
    logic [WIDTH-1:0]   w_step;
    logic               w_last_step;

    // SRL is an SRA step whose shifted-in bit is forced to zero.
    assign w_right_fill = (r_op == c_SHIFT_SRA) & r_work[WIDTH-1];

    my_1bit_rightshifter #(
        .WIDTH       (WIDTH)
    ) u_right (
        .control_bit (w_right_fill),
        .data_input  (r_work),
        .data_output (w_right)
    );

    my_1bit_leftshifter #(
        .WIDTH       (WIDTH)
    ) u_left (
        .control_bit (1'b0),
        .data_input  (r_work),
        .data_output (w_left)
    );

    assign w_step      = op_is_right(r_op) ? w_right : w_left;
    assign w_last_step = (r_count == SHAMT_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_data_out  <= '0;
            r_count     <= '0;
            r_op        <= c_SHIFT_SLL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            // Result register is left alone; it is meaningless while out_valid is low.
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work     <= data_in;
                        r_op       <= op;
                        r_count    <= shamt;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (shamt == '0) begin
                            r_state     <= ST_DONE;
                            r_data_out  <= data_in;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    r_work  <= w_step;
                    r_count <= r_count - SHAMT_W'(1);
                    if (w_last_step) begin
                        r_state     <= ST_DONE;
                        r_data_out  <= w_step;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_data_out;

endmodule

`default_nettype wire
